locker_ctrl: RTL
================

# locker_ctrl

Sequencing controller for the combination locker. It collects a multi-digit code entered one digit per `enter` strobe and compares it against a stored code. It drives the `open`/`error` indications, counts consecutive failures into a timed lockout, auto-relocks after a hold time, and lets a new code be programmed while the lock is open. It replaces the two-bit, single-shot combination check with a complete, reusable lock sequencer.

## Interface
- `DIGIT_W`, 4, bits per entered digit
- `CODE_LEN`, 4, digits per combination
- `MAX_FAIL`, 3, consecutive failures that trigger lockout (≥1)
- `LOCKOUT_CYC`, 16, lockout duration in clk cycles (≥1)
- `OPEN_CYC`, 8, open hold time in clk cycles before auto-relock (≥1)
- `RESET_CODE`, 16'h1234, stored code after reset, width CODE_LEN*DIGIT_W

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; forces all state and outputs to reset values
- `digit`  in  DIGIT_W  digit value, sampled only when `enter`=1
- `enter`  in  1  one-cycle strobe: accept `digit`
- `clear`  in  1  abort current entry/programming
- `lock`  in  1  relock request while open
- `prog`  in  1  enter programming mode while open
- `open`  out  1  lock released
- `error`  out  1  wrong code / lockout indication
- `lockout`  out  1  lockout timer running
- `entry_cnt`  out  clog2(CODE_LEN+1)  digits collected so far in ENTRY/PROG
- `fail_cnt`  out  clog2(MAX_FAIL+1)  consecutive failures

## Operation
- Moore machine. `open`, `error` and `lockout` are decoded from the state register only.
- States: IDLE, ENTRY, CHECK, OPEN, PROG, ERROR, LOCKOUT.
- Reset: state=IDLE, stored code=RESET_CODE, entry_cnt=0, fail_cnt=0, timers=0, open=0, error=0, lockout=0.
- Digit order: the first digit entered is compared with the most significant DIGIT_W slice of the code. Entering 1,2,3,4 matches 16'h1234.
- IDLE: `enter` stores the digit in slot 0; entry_cnt=1; go to ENTRY. With CODE_LEN=1, go directly to CHECK.
- ENTRY: each `enter` stores the digit in slot entry_cnt and increments entry_cnt. The enter that completes CODE_LEN digits goes to CHECK.
- CHECK lasts exactly one cycle. entry_cnt returns to 0.
  - Match: go to OPEN; fail_cnt=0; open timer=OPEN_CYC.
  - Mismatch: fail_cnt+1. If the new value equals MAX_FAIL, go to LOCKOUT with timer=LOCKOUT_CYC; otherwise go to ERROR.
- ERROR: error=1. Held until `clear`, then go to IDLE. `enter` is ignored.
- LOCKOUT: error=1, lockout=1. All inputs are ignored, including `clear`. When the timer expires, go to IDLE with fail_cnt=0.
- OPEN: open=1; the timer decrements every cycle.
  - `lock` or timer expiry: go to IDLE.
  - `prog`: go to PROG.
  - `enter` is ignored.
- PROG: open=1; digits are collected exactly as in ENTRY into a shadow register.
  - After the CODE_LEN-th digit: the stored code is replaced, then go to OPEN with the timer reloaded to OPEN_CYC.
  - `clear`: discard the shadow and keep the old code; go to OPEN with the timer reloaded.
  - The timer does not run in PROG.
- `clear` in IDLE/ENTRY: entry_cnt=0; go to IDLE. fail_cnt is unchanged.
- Priority within a state:
  - `clear` beats `enter`.
  - `lock` beats `prog`.
  - `lock`/`prog` beat timer expiry in the same cycle.
- Digit values are compared raw; there is no range check on `digit`.

## Timing
- The last `enter` is sampled at edge k, giving CHECK after k. open=1 or error=1 is visible after edge k+1, so latency is 2 cycles.
- open stays high exactly OPEN_CYC cycles when there is no `lock`/`prog`; it falls after the edge where the timer reaches 0.
- lockout stays high exactly LOCKOUT_CYC cycles.
- `lock` sampled at edge j: open=0 after edge j.
- New code takes effect from the CHECK following the next ENTRY.
- Asynchronous reset mid-operation (any state, including PROG partway): immediate return to reset values. A partially programmed code is lost and RESET_CODE is restored.
- Strobes held high for multiple cycles count once per cycle. The upstream block supplies single-cycle pulses.

## Test plan
- Reset, then enter 1,2,3,4 → CHECK one cycle later; open=1 for exactly 8 cycles; fail_cnt=0; then back to IDLE.
- Enter 1,2,3,5 → error=1, fail_cnt=1, held until `clear`. Then 1,2,3,4 → open=1 and fail_cnt=0.
- Three wrong codes with `clear` between them → third gives lockout=1 and error=1 for 16 cycles. `enter`/`clear` during lockout have no effect; afterwards IDLE with fail_cnt=0.
- In OPEN, pulse `prog`, enter 9,8,7,6 → open held, timer reloaded. `lock`, then 1,2,3,4 → error; 9,8,7,6 → open.
- Enter 1,2 then `clear` with simultaneous `enter` → entry_cnt=0, IDLE; the next 1,2,3,4 opens. In PROG enter 5,5 then `clear` → old code 1234 still opens.
- Assert `reset` mid-PROG (two digits in) and mid-LOCKOUT → all outputs 0 immediately; 1,2,3,4 opens afterwards.

Source files
------------

// File: rtl/locker_ctrl.sv
// Combination-lock sequencer: collects a CODE_LEN-digit entry, compares it
// with the stored code, holds the lock open for a bounded time, counts
// consecutive failures into a timed lockout and allows reprogramming while open.
module locker_ctrl #(
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned CODE_LEN    = 4,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCKOUT_CYC = 16,
    parameter int unsigned OPEN_CYC    = 8,
    parameter logic [CODE_LEN*DIGIT_W-1:0] RESET_CODE = 16'h1234
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DIGIT_W-1:0]                digit,
    input  logic                              enter,
    input  logic                              clear,
    input  logic                              lock,
    input  logic                              prog,
    output logic                              open,
    output logic                              error,
    output logic                              lockout,
    output logic [$clog2(CODE_LEN+1)-1:0]     entry_cnt,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

    localparam int unsigned CW   = $clog2(CODE_LEN + 1);
    localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
    localparam int unsigned KW   = CODE_LEN * DIGIT_W;
    localparam int unsigned TMAX = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] LAST_SLOT  = CW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAIL);
    localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_CYC);
    localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCKOUT_CYC);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    typedef enum logic [2:0] {
        StIdle, StEntry, StCheck, StOpen, StProg, StError, StLockout
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] code_q, code_d;
    logic [KW-1:0] buf_q, buf_d;    // entry digits, also the shadow while programming
    logic [KW-1:0] buf_ins;         // buf_q with the current digit dropped into its slot
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [FW-1:0] fail_inc;
    logic [TW-1:0] timer_q, timer_d;

    // Place the incoming digit in slot cnt_q; slot 0 is the most significant digit.
    always_comb begin
        buf_ins = buf_q;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (cnt_q == CW'(i)) begin
                buf_ins[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
            end
        end
    end

    assign fail_inc = fail_q + FW'(1);

    // Next-state logic for the sequencer, counters, timer and stored code.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        case (state_q)
            StIdle, StEntry: begin
                if (clear) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (enter) begin
                    buf_d = buf_ins;
                    if (cnt_q == LAST_SLOT) begin
                        cnt_d   = '0;
                        state_d = StCheck;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = StEntry;
                    end
                end
            end
            StCheck: begin
                if (buf_q == code_q) begin
                    fail_d  = '0;
                    timer_d = OPEN_LOAD;
                    state_d = StOpen;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == FAIL_LIMIT) begin
                        timer_d = LOCK_LOAD;
                        state_d = StLockout;
                    end else begin
                        state_d = StError;
                    end
                end
            end
            StError: begin
                if (clear) state_d = StIdle;
            end
            StLockout: begin
                if (timer_q <= TIMER_ONE) begin
                    timer_d = '0;
                    fail_d  = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            StOpen: begin
                if (lock) begin
                    timer_d = '0;
                    state_d = StIdle;
                end else if (prog) begin
                    cnt_d   = '0;
                    state_d = StProg;
                end else if (timer_q <= TIMER_ONE) begin
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            StProg: begin
                // Timer is frozen here; every exit reloads it.
                if (clear) begin
                    cnt_d   = '0;
                    timer_d = OPEN_LOAD;
                    state_d = StOpen;
                end else if (enter) begin
                    buf_d = buf_ins;
                    if (cnt_q == LAST_SLOT) begin
                        code_d  = buf_ins;
                        cnt_d   = '0;
                        timer_d = OPEN_LOAD;
                        state_d = StOpen;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with asynchronous reset restoring the factory code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            code_q  <= RESET_CODE;
            buf_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        open    = (state_q == StOpen) || (state_q == StProg);
        error   = (state_q == StError) || (state_q == StLockout);
        lockout = (state_q == StLockout);
    end

    assign entry_cnt = cnt_q;
    assign fail_cnt  = fail_q;

endmodule
